alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Instruction sequencer that drives the select and enable inputs of the three ALU result muxes feeding registers A, B and Y. It accepts packed instructions over a valid/ready handshake, buffers them in a small FIFO, and issues them one per cycle. Each issued instruction may repeat a programmable number of cycles, for example multi-bit shifts. The block sits upstream of the mux/register datapath and is its only source of `sel_*`/`enable_*`.

## Interface
- `DEPTH`, default 4: instruction FIFO depth. Must be a power of 2 and ≥2.
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  asynchronous, active-low. `reset==0` clears all state.
- `instr_valid`  input  1  upstream presents an instruction.
- `instr_ready`  output  1  FIFO can accept. Equals `!full`.
- `instr`  input  11  `[3:0]` op, `[6:4]` dst mask (bit4 A, bit5 B, bit6 Y), `[10:7]` rpt.
- `sel_A`, `sel_B`, `sel_Y`  output  4 each  mux selects, registered.
- `enable_A`, `enable_B`, `enable_Y`  output  1 each  mux enables, registered.
- `busy`  output  1  FIFO non-empty or FSM in EXEC.
- `err`  output  1  one-cycle pulse on a dropped instruction. Tied 0 without the macro.

## Operation
- Op encoding, which is also the sel value:
  - ADD=0, SUB=1, SHL=2, SHR=3, CMP=4, AND=5, OR=6, XOR=7
  - NAND=8, NOR=9, XNOR=10, NOT=11, INV=12, NEG=13, STO=14, SWP=15
- Push: on a `clk` rising edge with `instr_valid && instr_ready`, the instruction is written at the write pointer. A push while full cannot occur because ready is low.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the rest are equal.
- FSM states: IDLE, EXEC.
  - **IDLE:**
    - If the FIFO is non-empty: pop, load outputs, set `rpt_cnt = rpt`, go to EXEC.
    - Otherwise stay in IDLE with all enables 0.
  - **EXEC, `rpt_cnt != 0`:** hold the outputs and decrement `rpt_cnt`.
  - **EXEC, `rpt_cnt == 0`:**
    - If the FIFO is non-empty: pop the next instruction and load it back-to-back with no bubble; stay in EXEC.
    - Otherwise drive all enables to 0 and go to IDLE.
- Loading outputs:
  - For each dst bit set: the matching `sel_*` gets the op and the matching `enable_*` goes to 1.
  - For each dst bit clear: the matching `enable_*` goes to 0 and `sel_*` holds its previous value.
- An instruction with rpt=n asserts its enables for exactly n+1 consecutive cycles.
- Push and pop in the same cycle are both honoured. The occupancy count is unchanged.
- In IDLE, `sel_*` hold their last issued values.
- Reset values:
  - All `sel_*` = 4'h0.
  - All `enable_*` = 0.
  - `busy` = 0, `err` = 0.
  - `instr_ready` = 1.
  - FIFO empty, FSM in IDLE, `rpt_cnt` = 0.
- Reset asserted mid-EXEC discards the current instruction and all FIFO contents immediately, without waiting for a clock edge.

## Timing
- Push at edge t into an empty FIFO with the FSM in IDLE: enables are high in cycle t+1.
- Downstream registers capture at edge t+2.
- Push-to-issue latency is 1 cycle. Throughput is 1 instruction per cycle when every rpt=0.
- `instr_ready` is combinational from the pointers only. It does not depend on `instr_valid`.
- `busy` is combinational. It is low only when the FIFO is empty and the FSM is in IDLE.

## Configuration
- `ALU_SEQ_DST_CHECK_EN` **defined:**
  - An instruction popped with dst=000 is dropped.
  - It consumes exactly one issue cycle with all enables 0, and `err` pulses high in that cycle.
  - Its rpt field is ignored.
- `ALU_SEQ_DST_CHECK_EN` **undefined:**
  - dst=000 instructions execute normally: rpt+1 cycles, all enables 0.
  - `err` is constant 0.

## Test plan
- **Reset then single op:** after reset release, push instr=11'h075 (AND, dst=A|B|Y, rpt=0).
  - Next cycle: all sels=5, all enables=1 for exactly one cycle.
  - Following cycle: enables=0, `busy`=0.
- **Repeat:** push SHL, dst=A, rpt=3 (instr=11'h192).
  - `enable_A`=1 and `sel_A`=2 for 4 consecutive cycles.
  - `enable_B`=`enable_Y`=0 throughout.
- **Back-to-back and full:** with DEPTH=4, hold `instr_valid` high while issue is stalled behind an rpt=15 op.
  - `instr_ready` drops after 4 accepted pushes.
  - Queued ops issue on consecutive cycles with no bubble.
- **Wrap-around:** stream 20 ops with distinct op/dst values through DEPTH=4 under random valid gaps.
  - The issued sequence matches the pushed sequence exactly.
- **Async reset mid-EXEC:** pulse `reset` low during cycle 2 of an rpt=7 op with 3 ops queued.
  - Enables go to 0 immediately.
  - After release: `busy`=0, `instr_ready`=1, and nothing issues.
- **Illegal dst:** push instr=11'h181 (dst=000, rpt=3).
  - With the macro: one cycle of zero enables with `err`=1, then IDLE.
  - Without the macro: 4 cycles of zero enables with `err`=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Instruction FIFO plus IDLE/EXEC issue FSM that drives the A/B/Y result-mux selects and enables.
// Optional build macro ALU_SEQ_DST_CHECK_EN: drop dst=000 instructions with a one-cycle err pulse.
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [10:0] instr,
    output logic [3:0]  sel_A,
    output logic [3:0]  sel_B,
    output logic [3:0]  sel_Y,
    output logic        enable_A,
    output logic        enable_B,
    output logic        enable_Y,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t      r_state, w_state_nxt;
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [10:0] r_mem [DEPTH];
    logic [10:0] w_head;
    logic        w_empty, w_full, w_push, w_pop;
    logic [3:0]  r_rpt_cnt, w_rpt_nxt;
    logic [3:0]  r_sel_a, r_sel_b, r_sel_y;
    logic [3:0]  w_sel_a_nxt, w_sel_b_nxt, w_sel_y_nxt;
    logic [2:0]  r_en, w_en_nxt;  // {Y, B, A}, same order as the dst field

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push      = instr_valid && !w_full;
    assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign instr_ready = !w_full;
    assign busy        = !w_empty || (r_state == EXEC);

    assign sel_A    = r_sel_a;
    assign sel_B    = r_sel_b;
    assign sel_Y    = r_sel_y;
    assign enable_A = r_en[0];
    assign enable_B = r_en[1];
    assign enable_Y = r_en[2];

`ifdef ALU_SEQ_DST_CHECK_EN
    logic r_err, w_err_nxt;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_rpt_nxt   = r_rpt_cnt;
        w_en_nxt    = r_en;
        w_sel_a_nxt = r_sel_a;
        w_sel_b_nxt = r_sel_b;
        w_sel_y_nxt = r_sel_y;
        w_pop       = 1'b0;
`ifdef ALU_SEQ_DST_CHECK_EN
        w_err_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_en_nxt = 3'b000;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (r_rpt_cnt != 4'd0) begin
                    w_rpt_nxt = r_rpt_cnt - 4'd1;
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                end else begin
                    w_en_nxt    = 3'b000;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Loading a popped instruction: lanes without their dst bit keep the previous select.
        if (w_pop) begin
            w_en_nxt  = w_head[6:4];
            w_rpt_nxt = w_head[10:7];
            if (w_head[4]) w_sel_a_nxt = w_head[3:0];
            if (w_head[5]) w_sel_b_nxt = w_head[3:0];
            if (w_head[6]) w_sel_y_nxt = w_head[3:0];
`ifdef ALU_SEQ_DST_CHECK_EN
            if (w_head[6:4] == 3'b000) begin
                w_rpt_nxt = 4'd0;
                w_err_nxt = 1'b1;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rpt_cnt <= 4'd0;
            r_en      <= 3'b000;
            r_sel_a   <= 4'h0;
            r_sel_b   <= 4'h0;
            r_sel_y   <= 4'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_nxt;
            r_en      <= w_en_nxt;
            r_sel_a   <= w_sel_a_nxt;
            r_sel_b   <= w_sel_b_nxt;
            r_sel_y   <= w_sel_y_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

`ifdef ALU_SEQ_DST_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err <= 1'b0;
        else        r_err <= w_err_nxt;
    end
`endif

    // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= instr;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (DEPTH=4), one task per scenario.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [10:0] instr;
    logic [3:0]  sel_A, sel_B, sel_Y;
    logic        enable_A, enable_B, enable_Y;
    logic        busy, err;
    logic [2:0]  en;

    int n_chk = 0;
    int n_err = 0;

    alu_op_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .sel_A(sel_A), .sel_B(sel_B), .sel_Y(sel_Y),
        .enable_A(enable_A), .enable_B(enable_B), .enable_Y(enable_Y),
        .busy(busy), .err(err)
    );

    assign en = {enable_Y, enable_B, enable_A};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [10:0] ins);
        instr_valid = 1'b1;
        instr       = ins;
        tick();
        instr_valid = 1'b0;
    endtask

    // Stream op i: op = i mod 16, dst = (i mod 7) + 1, rpt = 0.
    function automatic logic [10:0] mk(input int i);
        logic [3:0] op;
        logic [2:0] dst;
        op  = 4'(i % 16);
        dst = 3'((i % 7) + 1);
        return {4'd0, dst, op};
    endfunction

    task automatic test_reset;
        reset = 1'b0; instr_valid = 1'b0; instr = '0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (en !== 3'b000) begin n_err++; $display("FAIL reset_en got %b exp 000", en); end
        n_chk++; if ({sel_A, sel_B, sel_Y} !== 12'h000) begin n_err++; $display("FAIL reset_sel got %h exp 000", {sel_A, sel_B, sel_Y}); end
        n_chk++; if (busy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reset_busy_err got %b%b exp 00", busy, err); end
        n_chk++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", instr_ready); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single;
        push(11'h075);
        n_chk++; if (busy !== 1'b1 || en !== 3'b000) begin n_err++; $display("FAIL single_pending got busy=%b en=%b exp busy=1 en=000", busy, en); end
        tick();
        n_chk++; if (en !== 3'b111) begin n_err++; $display("FAIL single_en got %b exp 111", en); end
        n_chk++; if ({sel_A, sel_B, sel_Y} !== 12'h555) begin n_err++; $display("FAIL single_sel got %h exp 555", {sel_A, sel_B, sel_Y}); end
        tick();
        n_chk++; if (en !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL single_done got en=%b busy=%b exp en=000 busy=0", en, busy); end
        n_chk++; if ({sel_A, sel_B, sel_Y} !== 12'h555) begin n_err++; $display("FAIL single_sel_hold got %h exp 555", {sel_A, sel_B, sel_Y}); end
    endtask

    task automatic test_repeat;
        push(11'h192);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (en !== 3'b001 || sel_A !== 4'd2) begin n_err++; $display("FAIL repeat_c%0d got en=%b selA=%0d exp en=001 selA=2", i, en, sel_A); end
            n_chk++; if (sel_B !== 4'd5 || sel_Y !== 4'd5) begin n_err++; $display("FAIL repeat_hold_c%0d got selB=%0d selY=%0d exp 5 5", i, sel_B, sel_Y); end
        end
        tick();
        n_chk++; if (en !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL repeat_end got en=%b busy=%b exp en=000 busy=0", en, busy); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] q [4];
        int k, guard, n_big;
        logic acc;
        q[0] = 11'h021; q[1] = 11'h047; q[2] = 11'h056; q[3] = 11'h079;
        push(11'h790);
        tick();
        n_chk++; if (en !== 3'b001 || sel_A !== 4'd0) begin n_err++; $display("FAIL b2b_big_start got en=%b selA=%0d exp en=001 selA=0", en, sel_A); end
        n_big = 1;
        k = 0; guard = 0;
        while (k < 4 && guard < 10) begin
            instr_valid = 1'b1;
            instr       = q[k];
            acc         = instr_ready;
            tick();
            guard++;
            if (acc) k++;
            if (en == 3'b001 && sel_A == 4'd0) n_big++;
        end
        instr_valid = 1'b0;
        n_chk++; if (k !== 4 || guard !== 4) begin n_err++; $display("FAIL b2b_accepts got %0d in %0d cycles exp 4 in 4", k, guard); end
        n_chk++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready got %b exp 0", instr_ready); end
        guard = 0;
        while (en != 3'b010 && guard < 40) begin
            tick();
            guard++;
            if (en == 3'b001 && sel_A == 4'd0) n_big++;
        end
        n_chk++; if (n_big !== 16) begin n_err++; $display("FAIL b2b_rpt15_len got %0d exp 16", n_big); end
        n_chk++; if (en !== 3'b010 || sel_B !== 4'd1) begin n_err++; $display("FAIL b2b_q0 got en=%b selB=%0d exp en=010 selB=1", en, sel_B); end
        tick();
        n_chk++; if (en !== 3'b100 || sel_Y !== 4'd7) begin n_err++; $display("FAIL b2b_q1 got en=%b selY=%0d exp en=100 selY=7", en, sel_Y); end
        tick();
        n_chk++; if (en !== 3'b101 || sel_A !== 4'd6 || sel_Y !== 4'd6 || sel_B !== 4'd1) begin n_err++; $display("FAIL b2b_q2 got en=%b sel=%h exp en=101 sel=616", en, {sel_A, sel_B, sel_Y}); end
        tick();
        n_chk++; if (en !== 3'b111 || {sel_A, sel_B, sel_Y} !== 12'h999) begin n_err++; $display("FAIL b2b_q3 got en=%b sel=%h exp en=111 sel=999", en, {sel_A, sel_B, sel_Y}); end
        tick();
        n_chk++; if (en !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_end got en=%b busy=%b exp en=000 busy=0", en, busy); end
    endtask

    task automatic test_wrap;
        int issued, cyc;
        issued = 0;
        fork
            begin : driver
                for (int i = 0; i < 20; i++) begin
                    int gap, g;
                    gap = int'($urandom_range(0, 2));
                    repeat (gap) tick();
                    instr_valid = 1'b1;
                    instr       = mk(i);
                    g = 0;
                    while (!instr_ready && g < 50) begin tick(); g++; end
                    tick();
                    instr_valid = 1'b0;
                end
            end
            begin : monitor
                logic [10:0] e_ins;
                cyc = 0;
                while (issued < 20 && cyc < 300) begin
                    tick();
                    cyc++;
                    if (en != 3'b000) begin
                        e_ins = mk(issued);
                        n_chk++; if (en !== e_ins[6:4]) begin n_err++; $display("FAIL wrap_en_%0d got %b exp %b", issued, en, e_ins[6:4]); end
                        if (e_ins[4]) begin n_chk++; if (sel_A !== e_ins[3:0]) begin n_err++; $display("FAIL wrap_selA_%0d got %0d exp %0d", issued, sel_A, e_ins[3:0]); end end
                        if (e_ins[5]) begin n_chk++; if (sel_B !== e_ins[3:0]) begin n_err++; $display("FAIL wrap_selB_%0d got %0d exp %0d", issued, sel_B, e_ins[3:0]); end end
                        if (e_ins[6]) begin n_chk++; if (sel_Y !== e_ins[3:0]) begin n_err++; $display("FAIL wrap_selY_%0d got %0d exp %0d", issued, sel_Y, e_ins[3:0]); end end
                        issued++;
                    end
                end
            end
        join
        n_chk++; if (issued !== 20) begin n_err++; $display("FAIL wrap_count got %0d exp 20", issued); end
        tick();
        tick();
        n_chk++; if (busy !== 1'b0 || en !== 3'b000) begin n_err++; $display("FAIL wrap_drain got busy=%b en=%b exp busy=0 en=000", busy, en); end
    endtask

    task automatic test_async_reset;
        push(11'h3B3);
        push(11'h012);
        push(11'h024);
        push(11'h046);
        n_chk++; if (en !== 3'b011 || sel_A !== 4'd3 || busy !== 1'b1) begin n_err++; $display("FAIL arst_pre got en=%b selA=%0d busy=%b exp en=011 selA=3 busy=1", en, sel_A, busy); end
        #2 reset = 1'b0;
        #1;
        n_chk++; if (en !== 3'b000) begin n_err++; $display("FAIL arst_en got %b exp 000", en); end
        n_chk++; if (busy !== 1'b0 || instr_ready !== 1'b1) begin n_err++; $display("FAIL arst_state got busy=%b ready=%b exp busy=0 ready=1", busy, instr_ready); end
        n_chk++; if ({sel_A, sel_B, sel_Y} !== 12'h000) begin n_err++; $display("FAIL arst_sel got %h exp 000", {sel_A, sel_B, sel_Y}); end
        #2 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (en !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL arst_after_c%0d got en=%b busy=%b exp en=000 busy=0", i, en, busy); end
        end
    endtask

    task automatic test_illegal_dst;
        push(11'h181);
`ifdef ALU_SEQ_DST_CHECK_EN
        tick();
        n_chk++; if (en !== 3'b000 || err !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL illegal_drop got en=%b err=%b busy=%b exp 000 1 1", en, err, busy); end
        tick();
        n_chk++; if (err !== 1'b0 || busy !== 1'b0 || en !== 3'b000) begin n_err++; $display("FAIL illegal_idle got en=%b err=%b busy=%b exp 000 0 0", en, err, busy); end
`else
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (en !== 3'b000 || err !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL illegal_c%0d got en=%b err=%b busy=%b exp 000 0 1", i, en, err, busy); end
        end
        tick();
        n_chk++; if (busy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL illegal_idle got busy=%b err=%b exp 0 0", busy, err); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_illegal_dst();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
